// File: rtl/player_input.sv
// player_input: front-end stage between the two raw player pushbuttons and
// the game-logic FSM. Each player channel synchronizes its asynchronous,
// active-low button, debounces it, and produces a one-cycle press pulse
// plus a debounced "held" level.
//
// Optional feature macro: PLAYER_INPUT_REPEAT_EN
//   When defined, a held button also re-pulses: first after REPEAT_DELAY
//   cycles in the pressed state, then every REPEAT_PERIOD cycles, until the
//   release is accepted. When undefined, each accepted press yields exactly
//   one pulse and the repeat logic does not exist.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed to accept
//                    a level change (must be >= 2)
//   REPEAT_DELAY     cycles in PRESSED before the first repeat pulse
//   REPEAT_PERIOD    cycles between subsequent repeat pulses
//
// Ports (player_input):
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   p1btn_n  in   raw player-1 button, 0 = pressed, asynchronous
//   p2btn_n  in   raw player-2 button, 0 = pressed, asynchronous
//   p1data   out  one-cycle press pulse, player 1 (registered)
//   p2data   out  one-cycle press pulse, player 2 (registered)
//   p1held   out  debounced level, player 1, 1 = pressed (registered)
//   p2held   out  debounced level, player 2, 1 = pressed (registered)
//
// The per-channel FSM state is held in player_input_chan.state_q
// (u_p1 / u_p2 instances) for checkers to observe.

// ---------------------------------------------------------------------------
// One player channel: 2-flop synchronizer, debounce FSM, output registers.
//   clk, reset  as above
//   btn_n       raw active-low button
//   data        one-cycle press (and optional repeat) pulse
//   held        debounced pressed level
// ---------------------------------------------------------------------------
module player_input_chan #(
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int REPEAT_DELAY    = 24000000,
  parameter int REPEAT_PERIOD   = 4800000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic data,
  output logic held
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The entry sample counts as the first stable sample, so the FSM moves on
  // when the counter already holds DEBOUNCE_CYCLES-2 and one more stable
  // sample arrives (the count then reaches DEBOUNCE_CYCLES-1).
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Synchronizer; inverted so that s = 1 means pressed.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic s;

  state_t         state_q, state_d;
  logic  [CW-1:0] cnt_q, cnt_d;
  logic           evt_q, evt_d;
  logic           data_q, data_d;
  logic           held_q, held_d;

  logic press_entry;
  logic rep_fire;

  assign sync1_d = ~btn_n;
  assign sync2_d = sync1_q;
  assign s       = sync2_q;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
      data_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      data_q  <= data_d;
      held_q  <= held_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // Going back to PRESSED here is release bounce: no new pulse.
        if (s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Only a fresh press (not a bounce back from RELEASE_WAIT) makes a pulse.
  assign press_entry = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);

`ifdef PLAYER_INPUT_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REP_MAX  = {RW{1'b1}};

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_first_q, rep_first_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end

  // The repeat timer starts on a fresh press, keeps running through release
  // bounce, and is cleared only when the release is accepted. A repeat that
  // would coincide with the accepted release is suppressed.
  always_comb begin
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (press_entry || (state_d == ST_IDLE)) begin
      rep_d       = '0;
      rep_first_d = 1'b1;
    end else if ((state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT)) begin
      if (rep_q == (rep_first_q ? DLY_LAST : PER_LAST)) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // ---------------- output logic ----------------
  // evt_q marks the cycle the FSM enters PRESSED (or a repeat is due);
  // data_q is the registered pulse seen one cycle later.
  always_comb begin
    evt_d  = press_entry | rep_fire;
    data_d = evt_q;
    held_d = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  end

  assign data = data_q;
  assign held = held_q;

endmodule

// ---------------------------------------------------------------------------
// Top: two identical, independent channels; no arbitration between them.
// ---------------------------------------------------------------------------
module player_input #(
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int REPEAT_DELAY    = 24000000,
  parameter int REPEAT_PERIOD   = 4800000
) (
  input  logic clk,
  input  logic reset,
  input  logic p1btn_n,
  input  logic p2btn_n,
  output logic p1data,
  output logic p2data,
  output logic p1held,
  output logic p2held
);

  player_input_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_p1 (
    .clk   (clk),
    .reset (reset),
    .btn_n (p1btn_n),
    .data  (p1data),
    .held  (p1held)
  );

  player_input_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_p2 (
    .clk   (clk),
    .reset (reset),
    .btn_n (p2btn_n),
    .data  (p2data),
    .held  (p2held)
  );

endmodule
